// File: rtl/my_struct_package.sv
// Shared types and geometry for the L1 trace-command sequencer.
// STAT_COUNTERS_EN (see cache_access_sequencer) selects whether statistics counters are built.
package my_struct_package;
  localparam int SETS     = 16384;
  localparam int INDEX_W  = 14;
  localparam int TAG_W    = 12;
  localparam int OFFSET_W = 6;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
  localparam int CNT_W    = 32;

  typedef enum logic [3:0] {
    OP_RD_D  = 4'd0,
    OP_WR_D  = 4'd1,
    OP_RD_I  = 4'd2,
    OP_INV   = 4'd3,
    OP_SNOOP = 4'd4,
    OP_CLR   = 4'd8,
    OP_PRINT = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    EVAL,
    WRITE,
    CLEAR,
    DONE
  } seq_state_e;

  // Ops that walk the lookup/eval/write path through a cache.
  function automatic logic op_is_mem(input logic [3:0] op);
    return op <= 4'd4;
  endfunction

  // Ops whose outcome is tallied as a hit or a miss (and refresh LRU).
  function automatic logic op_is_counted(input logic [3:0] op);
    return op <= 4'd2;
  endfunction
endpackage

// File: rtl/cache_access_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/cache_access_sequencer.sv
// Sequences lookup/update/clear phases for the split L1 caches; optional hit/miss
// statistics are built only when STAT_COUNTERS_EN is defined.
module cache_access_sequencer
  import my_struct_package::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic               ic_read_enable,
  output logic               ic_write_enable,
  output logic               dc_read_enable,
  output logic               dc_write_enable,
  output logic [INDEX_W-1:0] index,
  output logic [TAG_W-1:0]   tag,
  output logic               clear_all,
  output logic               lru_update,
  input  logic               hit_i,
  input  logic               hit_d,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   cnt_reads,
  output logic [CNT_W-1:0]   cnt_writes,
  output logic [CNT_W-1:0]   cnt_hits,
  output logic [CNT_W-1:0]   cnt_misses
);
  seq_state_e       r_state;
  logic [3:0]       r_op;
  logic             w_sel_i;
  logic             w_unused_offset;

  assign w_sel_i         = (r_op == OP_RD_I);
  assign w_unused_offset = ^cmd_addr[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_op            <= '0;
      cmd_ready       <= 1'b1;
      ic_read_enable  <= 1'b0;
      ic_write_enable <= 1'b0;
      dc_read_enable  <= 1'b0;
      dc_write_enable <= 1'b0;
      clear_all       <= 1'b0;
      lru_update      <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      index           <= '0;
      tag             <= '0;
    end else begin
      ic_read_enable  <= 1'b0;
      ic_write_enable <= 1'b0;
      dc_read_enable  <= 1'b0;
      dc_write_enable <= 1'b0;
      clear_all       <= 1'b0;
      lru_update      <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op      <= cmd_op;
            tag       <= cmd_addr[ADDR_W-1 -: TAG_W];
            index     <= cmd_addr[OFFSET_W +: INDEX_W];
            cmd_ready <= 1'b0;
            if (cmd_op == OP_CLR) begin
              // Sweep starts at set 0 on the very next cycle.
              r_state         <= CLEAR;
              index           <= '0;
              ic_write_enable <= 1'b1;
              dc_write_enable <= 1'b1;
              clear_all       <= 1'b1;
            end else if (op_is_mem(cmd_op)) begin
              r_state <= LOOKUP;
              if (cmd_op == OP_RD_I) ic_read_enable <= 1'b1;
              else                   dc_read_enable <= 1'b1;
            end else begin
              r_state <= DONE;
              done    <= 1'b1;
              err     <= (cmd_op != OP_PRINT);
            end
          end
        end
        LOOKUP: r_state <= EVAL;
        EVAL: begin
          r_state    <= WRITE;
          lru_update <= op_is_counted(r_op);
          if (w_sel_i) ic_write_enable <= 1'b1;
          else         dc_write_enable <= 1'b1;
        end
        WRITE: begin
          r_state <= DONE;
          done    <= 1'b1;
        end
        CLEAR: begin
          if (index == INDEX_W'(SETS - 1)) begin
            r_state <= DONE;
            index   <= '0;
            done    <= 1'b1;
          end else begin
            index           <= index + 1'b1;
            ic_write_enable <= 1'b1;
            dc_write_enable <= 1'b1;
            clear_all       <= 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef STAT_COUNTERS_EN
  logic w_eval, w_hit, w_clr;

  assign w_eval = (r_state == EVAL);
  assign w_hit  = w_sel_i ? hit_i : hit_d;
  // Index is 0 only on the first sweep cycle, so this clears exactly once.
  assign w_clr  = (r_state == CLEAR) && (index == '0);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_reads (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_eval && ((r_op == OP_RD_D) || (r_op == OP_RD_I))), .count(cnt_reads));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_writes (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_eval && (r_op == OP_WR_D)), .count(cnt_writes));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_hits (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_eval && op_is_counted(r_op) && w_hit), .count(cnt_hits));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_misses (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_eval && op_is_counted(r_op) && !w_hit), .count(cnt_misses));
`else
  logic w_unused_hits;

  assign w_unused_hits = hit_i ^ hit_d;
  assign cnt_reads     = '0;
  assign cnt_writes    = '0;
  assign cnt_hits      = '0;
  assign cnt_misses    = '0;
`endif
endmodule

// File: doc/cache_access_sequencer.md
Name: cache_access_sequencer

Overview:
Trace-command sequencer between the command source and the split L1 caches. The instruction cache has 4 ways and the data cache has 8 ways; each has 16384 sets.
- Accepts one command_t per valid/ready handshake and splits the address into tag/index.
- Routes the command to the instruction or data cache.
- Sequences the read_enable (lookup) and write_enable (update) phases, plus the LRU update strobe.
- Runs the full-cache clear sweep and keeps hit/miss statistics.

Parameters:
SETS, 16384, sets per cache
INDEX_W, 14, index bits (log2 SETS)
TAG_W, 12, tag bits
OFFSET_W, 6, byte-offset bits (ADDR_W = TAG_W+INDEX_W+OFFSET_W)
ADDR_W, 32, address width
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  opcode: 0 data read, 1 data write, 2 instr fetch, 3 L2 invalidate, 4 L2 snoop read, 8 clear, 9 print
cmd_addr  in  ADDR_W  command address
ic_read_enable / ic_write_enable  out  1 each  instruction-cache lookup / update strobes
dc_read_enable / dc_write_enable  out  1 each  data-cache lookup / update strobes
index  out  INDEX_W  set index driven to both caches
tag  out  TAG_W  tag driven to both caches
clear_all  out  1  write phase is a clear (caches write MESI=I, LRU=way, tag=0)
lru_update  out  1  pulse to LRU counter in the write phase of ops 0,1,2
hit_i / hit_d  in  1 each  lookup result, valid the cycle after the read strobe
done  out  1  one-cycle pulse on command completion
err  out  1  one-cycle pulse with done for unsupported opcode
cnt_reads, cnt_writes, cnt_hits, cnt_misses  out  CNT_W each  statistics

Behaviour:
- Reset (rst=0, async): state IDLE. All strobes, done, err, clear_all and lru_update are 0. index=0, tag=0, counters=0, cmd_ready=1. Reset takes effect mid-command or mid-sweep with no completion pulse.
- States and cycles:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/addr; tag=addr[31:20], index=addr[19:6].
    - op 8 -> CLEAR.
    - op 9, 5-7 or 10-15 -> DONE.
    - otherwise -> LOOKUP.
  - LOOKUP (1 cycle): assert the selected read strobe. Op 2 selects the I-cache; ops 0,1,3,4 select the D-cache.
  - EVAL (1 cycle): sample the selected hit_* input.
  - WRITE (1 cycle): assert the selected write strobe. lru_update=1 for ops 0,1,2, only when that op's counter update applies.
  - DONE (1 cycle): done=1; err=1 for unsupported ops; -> IDLE.
  - CLEAR: index counts 0..SETS-1, one set per cycle, with ic_write_enable=dc_write_enable=clear_all=1. Counters are zeroed on the first CLEAR cycle. After index SETS-1, index wraps to 0 and the state goes to DONE. The sweep takes exactly SETS cycles.
- Latency (handshake to done):
  - ops 0-4: 4 cycles.
  - op 9 and unsupported ops: 1 cycle.
  - op 8: SETS+1 cycles.
- Command handshake: cmd_ready=0 in every non-IDLE state, so no back-to-back acceptance. The earliest next accept is the cycle after DONE.
- Strobe rules: read and write strobes are never high in the same cycle. At most one cache is strobed outside CLEAR.
- Counters (at EVAL, all saturating at 2^CNT_W-1, no wrap):
  - cnt_reads +1 for ops 0,2; cnt_writes +1 for op 1.
  - For ops 0,1,2: cnt_hits +1 if hit, else cnt_misses +1.
  - Ops 3,4 do not count.
- hit_* inputs are ignored outside EVAL.

Optional Feature:
STAT_COUNTERS_EN
- Defined: the four counters are implemented as above.
- Undefined: no counter flops; cnt_* outputs are constant 0. All other behaviour is unchanged.

Decomposition:
- Shared package my_struct_package (existing) gains:
  - opcode enum (OP_RD_D=0, OP_WR_D=1, OP_RD_I=2, OP_INV=3, OP_SNOOP=4, OP_CLR=8, OP_PRINT=9);
  - sequencer state enum (IDLE, LOOKUP, EVAL, WRITE, CLEAR, DONE);
  - TAG_W/INDEX_W/OFFSET_W constants.
- Sub-module sat_counter (parameter CNT_W; inputs clk, rst, clr, inc; output count): saturating counter, instantiated 4x under STAT_COUNTERS_EN.

Test Plan:
- Reset mid-LOOKUP (op 0 in flight, rst low) -> all strobes 0 immediately, cmd_ready=1, no done.
- op 0, addr 32'h984DE132, hit_d=0 in EVAL:
  - tag=12'h984, index=14'h3784;
  - dc_read_enable high in cycle 1, dc_write_enable and lru_update high in cycle 3, done in cycle 4;
  - cnt_reads=1, cnt_misses=1.
- op 2, addr 32'h846DE107, hit_i=1 -> only ic_* strobes toggle, dc_* stay 0; cnt_hits=1.
- op 8 -> exactly 16384 cycles of both write strobes plus clear_all; index 0..16383, then done; counters read 0.
- op 6 -> done and err together 1 cycle after accept; no strobes.
- op 1 with hold cmd_valid=1 through completion -> second accept no earlier than the cycle after done.
- STAT_COUNTERS_EN undefined -> same traffic as the op 0 scenario, cnt_* stay 0.
